radix2_sdf_stage4: RTL and testbench
====================================

RADIX2_SDF_STAGE4 -- requirements
Module: radix2_sdf_stage4

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-high (asserted = 1).
REQ-004 SHALL have port in_valid, input, 1 bit: din_r/din_i carry a sample this cycle.
REQ-005 SHALL have ports din_r and din_i, input, 24 bit signed: input sample, two's complement, 8 fractional bits (1.0 = 256).
REQ-006 SHALL have ports w_r and w_i, input, 24 bit signed: twiddle factor from the twiddle ROM, same format, sampled combinationally.
REQ-007 SHALL have port out_valid, output, 1 bit, registered: dout_r/dout_i are valid.
REQ-008 SHALL have ports dout_r and dout_i, output, 24 bit signed, registered: stage result.
REQ-009 SHALL have port tw_idx, output, 2 bit: current diff-output position (0..3), for twiddle alignment checks.

Function
REQ-010 SHALL implement a radix-2 single-path delay-feedback butterfly stage with a 4-entry complex delay line (FIFO, 24+24 bit per entry).
REQ-011 SHALL keep a 3-bit sample counter idx that increments by 1 on each in_valid cycle and wraps 7->0; all state SHALL hold when in_valid=0 (pure stall, no bubbles inserted).
REQ-012 Phase A (idx[2]=0): SHALL push din into the delay line and pop the oldest entry D.
REQ-013 Phase A output: when primed=1, SHALL register dout = (D * W) >> 8 (complex multiply, W = w_r + j*w_i) with out_valid=1; when primed=0, out_valid=0.
REQ-014 Complex multiply SHALL use full 48-bit signed products, r = Dr*Wr - Di*Wi, i = Dr*Wi + Di*Wr, arithmetic shift right by 8, truncate to 24 bits, no rounding or saturation.
REQ-015 Phase B (idx[2]=1): SHALL pop D, register dout = D + din (24-bit wrap, no saturation) with out_valid=1, and push D - din into the delay line.
REQ-016 SHALL set primed=1 on the first phase-B sample after reset and keep it set until reset.
REQ-017 tw_idx SHALL equal idx[1:0]; twiddle index k SHALL be applied to the k-th diff of a group (W8^k, k = 0..3).
REQ-018 Latency: each output SHALL appear one clock after the accepted input that produces it; sums leave on inputs 4..7, diffs leave on inputs 0..3 of the next group.
REQ-019 out_valid SHALL be 0 in every cycle following a cycle with in_valid=0.
REQ-020 Diffs of the final group SHALL remain buffered until 4 further valid inputs arrive; no flush port.

Reset
REQ-021 While rst_n=1, asynchronously: idx=0, primed=0, delay line all zero, out_valid=0, dout_r=dout_i=0.
REQ-022 Reset asserted mid-group SHALL discard buffered data; the next valid input after release is treated as idx=0, unprimed.

Verification
REQ-023 Reset: assert rst_n mid-stream -> outputs 0 immediately; after release, first 4 valid inputs produce out_valid=0.
REQ-024 Sums: real inputs 256,512,768,1024,1280,1536,1792,2048 -> dout_r 1536,2048,2560,3072 on cycles after inputs 5..8, dout_i=0.
REQ-025 Diffs: then 4 more inputs with W = (256,0),(181,-181),(0,-256),(-181,-181) -> (-1024,0),(-724,724),(0,1024),(724,724).
REQ-026 Stall: drop in_valid for 3 cycles between inputs 6 and 7 of REQ-024 -> out_valid=0 during the gap, identical result sequence.
REQ-027 Wrap: inputs 0x7FFF00 and 0x000100 in paired positions -> sum wraps to 0x800000, no saturation.
REQ-028 tw_idx sequence over 16 continuous inputs SHALL be 0,1,2,3 repeating, aligned with the diff outputs.

Source files
------------

// File: rtl/radix2_sdf_stage4.sv
// Radix-2 single-path delay-feedback butterfly stage with a 4-entry complex delay line.
// Sums leave in the second half of each 8-sample group; twiddled diffs leave during the next group's first half.
module radix2_sdf_stage4 #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,      // active-high despite the name
    input  logic                in_valid,
    input  logic signed [W-1:0] din_r,
    input  logic signed [W-1:0] din_i,
    input  logic signed [W-1:0] w_r,
    input  logic signed [W-1:0] w_i,
    output logic                out_valid,
    output logic signed [W-1:0] dout_r,
    output logic signed [W-1:0] dout_i,
    output logic [1:0]          tw_idx
);
    logic [2:0]         idx;
    logic               primed;
    logic signed [W-1:0] dl_r [DEPTH];
    logic signed [W-1:0] dl_i [DEPTH];

    logic signed [W-1:0]   d_r, d_i;
    logic signed [W-1:0]   sum_r, sum_i, push_r, push_i;
    logic signed [2*W-1:0] dr_x, di_x, wr_x, wi_x;
    logic signed [2*W-1:0] prod_r, prod_i;
    logic                  unused_bits;

    assign tw_idx = idx[1:0];
    assign d_r    = dl_r[DEPTH-1];
    assign d_i    = dl_i[DEPTH-1];

    always_comb begin
        dr_x   = (2*W)'(d_r);
        di_x   = (2*W)'(d_i);
        wr_x   = (2*W)'(w_r);
        wi_x   = (2*W)'(w_i);
        prod_r = dr_x * wr_x - di_x * wi_x;
        prod_i = dr_x * wi_x + di_x * wr_x;
        sum_r  = d_r + din_r;
        sum_i  = d_i + din_i;
        // Phase B feeds the diff back so it re-emerges one half-group later for twiddling
        push_r = idx[2] ? (d_r - din_r) : din_r;
        push_i = idx[2] ? (d_i - din_i) : din_i;
    end

    assign unused_bits = ^{prod_r[2*W-1:W+8], prod_r[7:0], prod_i[2*W-1:W+8], prod_i[7:0]};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            idx       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (in_valid) begin
            idx     <= idx + 3'd1;
            dl_r[0] <= push_r;
            dl_i[0] <= push_i;
            for (int k = 1; k < DEPTH; k++) begin
                dl_r[k] <= dl_r[k-1];
                dl_i[k] <= dl_i[k-1];
            end
            if (idx[2]) begin
                primed    <= 1'b1;
                out_valid <= 1'b1;
                dout_r    <= sum_r;
                dout_i    <= sum_i;
            end else if (primed) begin
                out_valid <= 1'b1;
                dout_r    <= prod_r[W+7:8];
                dout_i    <= prod_i[W+7:8];
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_radix2_sdf_stage4.sv
// Directed bench for radix2_sdf_stage4: reset, sums, twiddled diffs, stall, wrap and tw_idx alignment.
module tb_radix2_sdf_stage4;
    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [23:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
    logic               out_valid;
    logic signed [23:0] dout_r, dout_i;
    logic [1:0]         tw_idx;

    int checks = 0;
    int errors = 0;

    int sum_exp [4] = '{1536, 2048, 2560, 3072};
    int twr [4]     = '{256, 181, 0, -181};
    int twi [4]     = '{0, -181, -256, -181};
    int dif_r [4]   = '{-1024, -724, 0, 724};
    int dif_i [4]   = '{0, 724, 1024, 724};

    radix2_sdf_stage4 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .w_r(w_r), .w_i(w_i),
        .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i), .tw_idx(tw_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle; optionally check tw_idx before the edge, outputs are stable #1 after it.
    task automatic step(input logic v, input int r, input int wr, input int wi, input int exp_tw);
        @(negedge clk);
        in_valid = v;
        din_r = 24'(r);
        din_i = '0;
        w_r = 24'(wr);
        w_i = 24'(wi);
        #1;
        if (exp_tw >= 0) chk("tw_idx", 32'(tw_idx), exp_tw);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_dout_r", dout_r, 0);
        chk("rst_dout_i", dout_i, 0);
        chk("rst_tw_idx", 32'(tw_idx), 0);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Diff group: din unused (zero), twiddles applied in order k = 0..3
    task automatic diff_group();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 0, twr[k], twi[k], k);
            chk("diff_valid", 32'(out_valid), 1);
            chk("diff_r", dout_r, dif_r[k]);
            chk("diff_i", dout_i, dif_i[k]);
        end
    endtask

    initial begin
        // Power-on reset
        #2;
        do_reset();

        // Sums: first half unprimed, second half produces sums
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 256 * (n + 1), 0, 0, n % 4);
            if (n < 4) chk("unprimed_valid", 32'(out_valid), 0);
            else begin
                chk("sum_valid", 32'(out_valid), 1);
                chk("sum_r", dout_r, sum_exp[n-4]);
                chk("sum_i", dout_i, 0);
            end
        end
        diff_group();

        // Mid-stream reset, then same sequence with a 3-cycle gap between inputs 6 and 7
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (n == 6) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 999, 0, 0, -1);
                    chk("gap_valid", 32'(out_valid), 0);
                end
            end
            step(1'b1, 256 * (n + 1), 0, 0, n % 4);
            if (n < 4) chk("post_rst_valid", 32'(out_valid), 0);
            else begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_sum_r", dout_r, sum_exp[n-4]);
            end
        end
        diff_group();

        // Wrap: 0x7FFF00 + 0x000100 wraps to 0x800000; the diff 0x7FFE00 survives the unit twiddle
        do_reset();
        for (int n = 0; n < 8; n++) begin
            step(1'b1, (n == 0) ? 32'h7FFF00 : (n == 4) ? 32'h000100 : 0, 0, 0, -1);
        end
        // Output from input 4 was overwritten; rerun precisely instead
        do_reset();
        for (int n = 0; n < 5; n++)
            step(1'b1, (n == 0) ? 32'h7FFF00 : (n == 4) ? 32'h000100 : 0, 0, 0, -1);
        chk("wrap_sum", dout_r, 32'shFF800000);
        for (int n = 5; n < 8; n++) step(1'b1, 0, 0, 0, -1);
        step(1'b1, 0, 256, 0, 0);
        chk("wrap_diff", dout_r, 32'h007FFE00);

        // tw_idx over 16 continuous inputs, and valid pattern after reset
        do_reset();
        for (int n = 0; n < 16; n++) begin
            step(1'b1, n, 256, 0, n % 4);
            chk("run_valid", 32'(out_valid), (n < 4) ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
